// File: rtl/ram_mover_pkg.sv
// Shared definitions for the RAM block mover: op encodings, FSM state
// enum, default geometry and a small state-classification helper.
package ram_mover_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned RAM_DEPTH      = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_COPY = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_COPY_RD   = 3'd2,
        ST_COPY_WR   = 3'd3,
        ST_SUM_RD    = 3'd4,
        ST_SUM_DRAIN = 3'd5,
        ST_FINISH    = 3'd6
    } state_e;

    // States in which an operation is still using the RAM.
    function automatic logic is_busy_state(input state_e s);
        return !(s == ST_IDLE || s == ST_FINISH);
    endfunction

endpackage

// File: rtl/ram_mover_addr_gen.sv
// Source/destination pointers and remaining-word counter for the block mover.
// Pointers wrap modulo the RAM depth. The *_c outputs present the address to
// issue this cycle (the base values while loading, otherwise the pointers);
// a step advances the matching pointer past the issued address.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   load                  capture src_base/dst_base/count_base
//   step_src/dst/count    advance source, destination, decrement count
//   src_c, dst_c          address to issue this cycle
//   last_word_c           every counted word has been issued
module ram_mover_addr_gen
    import ram_mover_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   count_base,
    input  logic                  step_src,
    input  logic                  step_dst,
    input  logic                  step_count,
    output logic [ADDR_WIDTH-1:0] src_c,
    output logic [ADDR_WIDTH-1:0] dst_c,
    output logic                  last_word_c
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_c;

    assign src_c       = load ? src_base   : src_q;
    assign dst_c       = load ? dst_base   : dst_q;
    assign count_c     = load ? count_base : count_q;
    assign last_word_c = (count_q == '0);

    // Natural binary overflow gives the modulo-depth wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
        end else begin
            src_q   <= src_c + ADDR_WIDTH'(step_src);
            dst_q   <= dst_c + ADDR_WIDTH'(step_dst);
            count_q <= count_c - CNT_WIDTH'(step_count);
        end
    end

endmodule

// File: rtl/ram_block_mover.sv
// Block fill / copy / checksum initiator for a single-port synchronous RAM
// with one cycle of read latency. start/busy/done handshake to the control
// unit; err is held until the next accepted command.
// Build option: RAM_BLOCK_MOVER_SUM_EN compiles in the SUM operation and its
// accumulator; without it SUM is rejected as an error and result reads 0.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   start, op, src_addr,
//   dst_addr, length, fill_value command, captured when start is accepted
//   busy, done, err, result      status back to the control unit
//   ram_write_enable,
//   ram_address, ram_data_in     RAM control/data pins
//   ram_data_out                 RAM registered read data
module ram_block_mover
    import ram_mover_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

    state_e state_q;
    state_e state_d;

    logic                  accept_c;
    logic                  cmd_err_c;
    logic                  len_zero_c;

    logic                  load;
    logic                  step_src;
    logic                  step_dst;
    logic                  step_count;
    logic [ADDR_WIDTH-1:0] src_c;
    logic [ADDR_WIDTH-1:0] dst_c;
    logic                  last_word_c;

    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] fill_c;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  busy_d;
    logic                  done_d;

    // Commands are taken in IDLE and also in FINISH so back-to-back
    // commands lose no cycle.
    assign accept_c   = start && (state_q == ST_IDLE || state_q == ST_FINISH);
    assign len_zero_c = (length == '0);
`ifdef RAM_BLOCK_MOVER_SUM_EN
    assign cmd_err_c  = (op == OP_RSVD) || (length > LEN_WIDTH'(DEPTH));
`else
    assign cmd_err_c  = (op == OP_RSVD) || (op == OP_SUM) || (length > LEN_WIDTH'(DEPTH));
`endif

    ram_mover_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .src_base    (src_addr),
        .dst_base    (dst_addr),
        .count_base  (length),
        .step_src    (step_src),
        .step_dst    (step_dst),
        .step_count  (step_count),
        .src_c       (src_c),
        .dst_c       (dst_c),
        .last_word_c (last_word_c)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; steps are issued together with the access they follow.
    // COPY counts words on the write, FILL and SUM on every access.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        step_src   = 1'b0;
        step_dst   = 1'b0;
        step_count = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    load = 1'b1;
                    if (cmd_err_c || len_zero_c) begin
                        state_d = ST_FINISH;
                    end else begin
                        case (op)
                            OP_FILL: begin
                                state_d    = ST_FILL;
                                step_dst   = 1'b1;
                                step_count = 1'b1;
                            end
                            OP_COPY: begin
                                state_d  = ST_COPY_RD;
                                step_src = 1'b1;
                            end
`ifdef RAM_BLOCK_MOVER_SUM_EN
                            OP_SUM: begin
                                state_d    = ST_SUM_RD;
                                step_src   = 1'b1;
                                step_count = 1'b1;
                            end
`endif
                            default: state_d = ST_FINISH;
                        endcase
                    end
                end
            end
            ST_FILL: begin
                if (last_word_c) begin
                    state_d = ST_FINISH;
                end else begin
                    step_dst   = 1'b1;
                    step_count = 1'b1;
                end
            end
            ST_COPY_RD: begin
                state_d    = ST_COPY_WR;
                step_dst   = 1'b1;
                step_count = 1'b1;
            end
            ST_COPY_WR: begin
                if (last_word_c) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d  = ST_COPY_RD;
                    step_src = 1'b1;
                end
            end
`ifdef RAM_BLOCK_MOVER_SUM_EN
            ST_SUM_RD: begin
                if (last_word_c) begin
                    state_d = ST_SUM_DRAIN;
                end else begin
                    step_src   = 1'b1;
                    step_count = 1'b1;
                end
            end
            ST_SUM_DRAIN: state_d = ST_FINISH;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; registered below.
    always_comb begin
        we_d   = 1'b0;
        addr_d = '0;
        din_d  = '0;
        fill_c = accept_c ? fill_value : fill_q;
        case (state_d)
            ST_FILL: begin
                we_d   = 1'b1;
                addr_d = dst_c;
                din_d  = fill_c;
            end
            ST_COPY_RD: addr_d = src_c;
            ST_COPY_WR: begin
                we_d   = 1'b1;
                addr_d = dst_c;
            end
            ST_SUM_RD:  addr_d = src_c;
            default: ;
        endcase
        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            fill_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept_c) begin
                fill_q <= fill_value;
                err_q  <= cmd_err_c;
            end
        end
    end

`ifdef RAM_BLOCK_MOVER_SUM_EN
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] acc_q;

    // Read data arrives one cycle after its address; rd_pend_q marks it.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            rd_pend_q <= (state_q == ST_SUM_RD);
            if (accept_c) begin
                acc_q <= '0;
            end else if (rd_pend_q) begin
                acc_q <= acc_q + ram_data_out;
            end
        end
    end

    assign result = acc_q;
`else
    assign result = '0;
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign ram_address      = addr_q;
    // The RAM read register feeds the write port directly during COPY_WR,
    // so a word read in COPY_RD is written in the very next cycle.
    assign ram_data_in      = (state_q == ST_COPY_WR) ? ram_data_out : din_q;
    // Gate the write strobe with reset so the write in the reset cycle is dropped.
    assign ram_write_enable = we_q & ~reset;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM, write scoreboard, table of
// commands plus hand sequences for reset and back-to-back handshake.
module tb_ram_block_mover;
    import ram_mover_pkg::*;

    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam int unsigned DW = DEF_DATA_WIDTH;
`ifdef RAM_BLOCK_MOVER_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .fill_value       (fill_value),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .result           (result),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out)
    );

    always #5 clock = ~clock;

    // Behavioural RAM with a backdoor write port for preloading.
    logic [DW-1:0] mem     [RAM_DEPTH];
    logic [DW-1:0] exp_mem [RAM_DEPTH];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clock) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (ram_write_enable) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wq[$];
    wr_t wpop;

    // Every RAM write must match the next expected write.
    always @(negedge clock) begin
        if (ram_write_enable) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write required",
                         ram_address, ram_data_in);
            end else begin
                wpop = wq.pop_front();
                check("ram_write", {ram_address, ram_data_in}, {wpop.a, wpop.d});
            end
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [DW-1:0] fill;
        int            lat;
        logic          err;
        logic [DW-1:0] res;
        string         name;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] o, input int s, input int d, input int l,
                                input int f, input int lat, input bit e, input int r,
                                input string nm);
        vec_t v;
        v.op = o; v.src = AW'(s); v.dst = AW'(d); v.len = (AW+1)'(l);
        v.fill = DW'(f); v.lat = lat; v.err = e; v.res = DW'(r); v.name = nm;
        return v;
    endfunction

    // Reference model of the writes a command performs (ascending order).
    task automatic model_cmd(input logic [1:0] o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW:0] l, input logic [DW-1:0] f);
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        logic [DW-1:0] v;
        if (l == 0 || l > RAM_DEPTH) return;
        for (int i = 0; i < int'(l); i++) begin
            sa = AW'(s + i);
            da = AW'(d + i);
            if (o == 2'b00) begin
                wq.push_back('{da, f});
                exp_mem[da] = f;
            end else if (o == 2'b01) begin
                v = exp_mem[sa];
                wq.push_back('{da, v});
                exp_mem[da] = v;
            end
        end
    endtask

    task automatic preload(input int a, input int d);
        bd_en = 1'b1; bd_addr = AW'(a); bd_data = DW'(d);
        exp_mem[AW'(a)] = DW'(d);
        @(negedge clock);
        bd_en = 1'b0;
    endtask

    // Issue one command (called at a negedge) and check its completion.
    task automatic run_cmd(input vec_t v);
        int cyc;
        bit got;
        bit busy_ok;
        model_cmd(v.op, v.src, v.dst, v.len, v.fill);
        start = 1'b1; op = v.op; src_addr = v.src; dst_addr = v.dst;
        length = v.len; fill_value = v.fill;
        @(posedge clock);
        #1;
        start = 1'b0; op = 2'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
        length = (AW+1)'($urandom); fill_value = DW'($urandom);
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({v.name, "_latency"}, got ? cyc : -1, v.lat);
        check({v.name, "_busy_running"}, busy_ok, 1);
        check({v.name, "_busy_at_done"}, busy, 0);
        check({v.name, "_err"}, err, v.err);
        check({v.name, "_result"}, result, v.res);
        check({v.name, "_writes_left"}, wq.size(), 0);
        @(negedge clock);
        check({v.name, "_after_done"}, {done, err, result}, {1'b0, v.err, v.res});
    endtask

    vec_t vecs[11];
    logic [6:0] hs_busy;
    logic [6:0] hs_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0;
        @(negedge clock);
        for (int i = 0; i < int'(RAM_DEPTH); i++) begin
            if (i == 0) preload(i, 8'h05);
            else if (i == 30) preload(i, 8'hF0);
            else if (i == 31) preload(i, 8'h20);
            else preload(i, i * 7 + 1);
        end
        check("reset_outputs",
              {busy, done, err, result, ram_write_enable, ram_address, ram_data_in}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs",
              {busy, done, err, result, ram_write_enable, ram_address, ram_data_in}, 0);

        vecs[0]  = mk(2'b10, 30, 0, 3, 0, SUM_EN ? 5 : 1, !SUM_EN, SUM_EN ? 8'h15 : 0, "sum_wrap");
        vecs[1]  = mk(2'b00, 0, 4, 3, 8'hAA, 4, 0, 0, "fill_basic");
        vecs[2]  = mk(2'b11, 0, 0, 3, 0, 1, 1, 0, "op_rsvd");
        vecs[3]  = mk(2'b00, 0, 0, 33, 8'h99, 1, 1, 0, "len_33");
        vecs[4]  = mk(2'b01, 1, 2, 0, 0, 1, 0, 0, "copy_len0");
        vecs[5]  = mk(2'b01, 3, 4, 3, 0, 7, 0, 0, "copy_overlap");
        vecs[6]  = mk(2'b10, 4, 0, 3, 0, SUM_EN ? 5 : 1, !SUM_EN, SUM_EN ? 8'h42 : 0, "sum_small");
        vecs[7]  = mk(2'b00, 0, 30, 4, 8'h5A, 5, 0, 0, "fill_wrap");
        vecs[8]  = mk(2'b00, 0, 7, 32, 8'h3C, 33, 0, 0, "fill_full");
        vecs[9]  = mk(2'b10, 17, 0, 32, 0, SUM_EN ? 34 : 1, !SUM_EN, SUM_EN ? 8'h80 : 0, "sum_full");
        vecs[10] = mk(2'b10, 5, 0, 0, 0, 1, !SUM_EN, 0, "sum_len0");
        for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

        // Copy into the top of memory, wrapping past nothing below.
        preload(0, 8'h11);
        preload(1, 8'h22);
        preload(2, 8'h33);
        run_cmd(mk(2'b01, 0, 29, 3, 0, 7, 0, 0, "copy_top"));

        // Reset during the second write of an 8-word fill.
        wq.push_back('{AW'(8), DW'(8'h77)});
        exp_mem[8] = 8'h77;
        start = 1'b1; op = 2'b00; src_addr = '0; dst_addr = AW'(8); length = (AW+1)'(8);
        fill_value = 8'h77;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midop_reset_outputs",
              {busy, done, err, result, ram_write_enable, ram_address, ram_data_in}, 0);
        check("midop_reset_writes_left", wq.size(), 0);
        reset = 1'b0;
        run_cmd(mk(2'b00, 0, 12, 1, 8'hE1, 2, 0, 0, "post_reset_fill"));

        // Start held high: the second command is taken only in the done cycle.
        model_cmd(2'b01, AW'(16), AW'(20), (AW+1)'(2), '0);
        model_cmd(2'b00, '0, AW'(24), (AW+1)'(1), DW'(8'h99));
        start = 1'b1; op = 2'b01; src_addr = AW'(16); dst_addr = AW'(20); length = (AW+1)'(2);
        fill_value = '0;
        @(posedge clock);
        #1;
        op = 2'b00; src_addr = '0; dst_addr = AW'(24); length = (AW+1)'(1); fill_value = 8'h99;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            hs_busy[c] = busy;
            hs_done[c] = done;
            if (c == 4) begin
                @(posedge clock);
                #1 start = 1'b0;
            end
        end
        check("handshake_busy", hs_busy, 7'b0101111);
        check("handshake_done", hs_done, 7'b1010000);
        @(negedge clock);
        check("handshake_writes_left", wq.size(), 0);

        for (int i = 0; i < int'(RAM_DEPTH); i++)
            check($sformatf("mem_%0d", i), mem[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
